// File: rtl/detector_xicara_if.sv
// Signal bundle between detector_xicara and its environment: the sensor_xicara
// handshake (medir/pronto/timeout/tem_xicara) plus enable and status outputs.
interface detector_xicara_if;
  logic       habilita;
  logic       tem_xicara;
  logic       pronto;
  logic       timeout;
  logic       medir;
  logic       xicara_presente;
  logic       xicara_mudou;
  logic       erro_sensor;
  logic [2:0] db_estado;

  modport master (
    output habilita, tem_xicara, pronto, timeout,
    input  medir, xicara_presente, xicara_mudou, erro_sensor, db_estado
  );

  modport slave (
    input  habilita, tem_xicara, pronto, timeout,
    output medir, xicara_presente, xicara_mudou, erro_sensor, db_estado
  );
endinterface

// File: rtl/detector_xicara.sv
// detector_xicara: schedules sensor_xicara measurements, debounces cup presence and
// escalates repeated failures. Define DETECTOR_XICARA_WATCHDOG_EN for the AGUARDA watchdog.
module detector_xicara #(
  parameter int PERIODO       = 5000000,
  parameter int N_CONFIRMA    = 3,
  parameter int MAX_FALHAS    = 2,
  parameter int LIMITE_ESPERA = 60000000
) (
  input logic              clock,
  input logic              reset,
  detector_xicara_if.slave bus
);
  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    MEDE    = 3'd1,
    AGUARDA = 3'd2,
    AVALIA  = 3'd3,
    ESPERA  = 3'd4,
    ERRO    = 3'd5
  } estado_t;

  localparam int WP = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  localparam int WC = $clog2(N_CONFIRMA + 1);
  localparam int WF = $clog2(MAX_FALHAS + 1);
  localparam logic [WP-1:0] FIM_ESPERA = WP'(PERIODO - 1);
  localparam logic [WC-1:0] CONF_MAX   = WC'(N_CONFIRMA);
  localparam logic [WF-1:0] FALHA_MAX  = WF'(MAX_FALHAS);

  if (PERIODO < 1 || N_CONFIRMA < 1 || MAX_FALHAS < 1 || LIMITE_ESPERA < 1) begin : g_param_invalido
    $error("detector_xicara: all parameters must be >= 1");
  end

  estado_t       estado;
  logic [WP-1:0] cont_espera;
  logic [WC-1:0] cont_conf;
  logic [WF-1:0] cont_falha;
  logic          candidato;
  logic          amostra;
  logic          amostra_valida;
  logic          medir;
  logic          presente;
  logic          mudou;
  logic          erro;
  logic          estouro;
  logic [WC-1:0] conf_nova;
  logic [WF-1:0] falha_nova;

`ifdef DETECTOR_XICARA_WATCHDOG_EN
  localparam int WW = (LIMITE_ESPERA > 1) ? $clog2(LIMITE_ESPERA) : 1;
  localparam logic [WW-1:0] FIM_WD = WW'(LIMITE_ESPERA - 1);
  logic [WW-1:0] cont_wd;

  // Silence in AGUARDA for LIMITE_ESPERA cycles is handled like a timeout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cont_wd <= '0;
    else if (estado != AGUARDA || !bus.habilita)
      cont_wd <= '0;
    else if (cont_wd != FIM_WD)
      cont_wd <= cont_wd + 1'b1;
  end

  assign estouro = (estado == AGUARDA) && (cont_wd == FIM_WD);
`else
  assign estouro = 1'b0;
`endif

  always_comb begin
    conf_nova = WC'(1);
    if (amostra == candidato)
      conf_nova = (cont_conf == CONF_MAX) ? cont_conf : cont_conf + 1'b1;
    falha_nova = (cont_falha == FALHA_MAX) ? cont_falha : cont_falha + 1'b1;
  end

  // Dropping habilita behaves like a soft reset that never pulses xicara_mudou.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado         <= INICIAL;
      cont_espera    <= '0;
      cont_conf      <= '0;
      cont_falha     <= '0;
      candidato      <= 1'b0;
      amostra        <= 1'b0;
      amostra_valida <= 1'b0;
      medir          <= 1'b0;
      presente       <= 1'b0;
      mudou          <= 1'b0;
      erro           <= 1'b0;
    end else if (!bus.habilita) begin
      estado         <= INICIAL;
      cont_espera    <= '0;
      cont_conf      <= '0;
      cont_falha     <= '0;
      candidato      <= 1'b0;
      amostra        <= 1'b0;
      amostra_valida <= 1'b0;
      medir          <= 1'b0;
      presente       <= 1'b0;
      mudou          <= 1'b0;
      erro           <= 1'b0;
    end else begin
      medir <= 1'b0;
      mudou <= 1'b0;
      case (estado)
        INICIAL: begin
          estado <= MEDE;
          medir  <= 1'b1;
        end
        MEDE: begin
          estado         <= AGUARDA;
          amostra_valida <= 1'b0;
        end
        AGUARDA: begin
          if (bus.pronto) begin
            amostra        <= bus.tem_xicara;
            amostra_valida <= 1'b1;
            estado         <= AVALIA;
          end else if (bus.timeout || estouro) begin
            amostra_valida <= 1'b0;
            estado         <= AVALIA;
          end
        end
        AVALIA: begin
          cont_espera <= '0;
          if (amostra_valida) begin
            cont_falha <= '0;
            erro       <= 1'b0;
            candidato  <= amostra;
            cont_conf  <= conf_nova;
            if (conf_nova == CONF_MAX && amostra != presente) begin
              presente <= amostra;
              mudou    <= 1'b1;
            end
            estado <= ESPERA;
          end else begin
            cont_falha <= falha_nova;
            candidato  <= 1'b0;
            cont_conf  <= '0;
            // A persistent fault must not leave a stale "cup present" reported.
            if (falha_nova == FALHA_MAX) begin
              erro     <= 1'b1;
              presente <= 1'b0;
              mudou    <= presente;
              estado   <= ERRO;
            end else begin
              estado <= ESPERA;
            end
          end
        end
        ESPERA, ERRO: begin
          if (cont_espera == FIM_ESPERA) begin
            cont_espera <= '0;
            estado      <= MEDE;
            medir       <= 1'b1;
          end else begin
            cont_espera <= cont_espera + 1'b1;
          end
        end
        default: estado <= INICIAL;
      endcase
    end
  end

  assign bus.medir           = medir;
  assign bus.xicara_presente = presente;
  assign bus.xicara_mudou    = mudou;
  assign bus.erro_sensor     = erro;
  assign bus.db_estado       = estado;
endmodule
